// File: rtl/csr_pkg.sv
// Shared definitions for the machine counter CSR block: CSR addresses,
// mcountinhibit bit positions and the address decode helpers.
package csr_pkg;

    // Machine-mode counter CSRs (read/write).
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    // User-mode read-only shadows of the same counters.
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

    // mcountinhibit layout: only CY and IR are implemented, bit 1 (TM) is hardwired 0.
    localparam int          INH_CY    = 0;
    localparam int          INH_IR    = 2;
    localparam int          INH_WIDTH = 3;
    localparam logic [INH_WIDTH-1:0] INH_MASK =
        (INH_WIDTH'(1) << INH_CY) | (INH_WIDTH'(1) << INH_IR);

    // Which storage element a decoded address refers to.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CYCLE_LO,
        SEL_CYCLE_HI,
        SEL_INSTRET_LO,
        SEL_INSTRET_HI,
        SEL_INHIBIT
    } csr_sel_e;

    // Addresses with [11:10] == 2'b11 are read-only in the RISC-V CSR space.
    function automatic logic csr_is_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

    // Map an address onto the storage it selects; the user shadows alias the
    // machine counters.
    function automatic csr_sel_e csr_decode(input logic [11:0] addr);
        csr_sel_e sel;
        case (addr)
            CSR_MCYCLE,    CSR_CYCLE:    sel = SEL_CYCLE_LO;
            CSR_MCYCLEH,   CSR_CYCLEH:   sel = SEL_CYCLE_HI;
            CSR_MINSTRET,  CSR_INSTRET:  sel = SEL_INSTRET_LO;
            CSR_MINSTRETH, CSR_INSTRETH: sel = SEL_INSTRET_HI;
            CSR_MCOUNTINHIBIT:           sel = SEL_INHIBIT;
            default:                     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/split_counter64.sv
// A wide counter stored as two XLEN halves so each half can be written
// independently through the CSR path. A write to the low half replaces that
// cycle's increment entirely; a write to the high half lets the low half keep
// counting but swallows any carry that would have landed in the high half.
module split_counter64
    import csr_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 we_lo,
    input  logic                 we_hi,
    input  logic [XLEN-1:0]      wd,
    output logic [CNT_WIDTH-1:0] value
);

    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] hi_q;
    logic            lo_all_ones;
    logic            carry_to_hi;

    // The carry into the high half only exists when the low half actually
    // increments past all-ones, which a low-half write prevents.
    always_comb begin
        lo_all_ones = &lo_q;
        carry_to_hi = inc && lo_all_ones && !we_lo;
    end

    // Low half: write data wins over the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q <= '0;
        end else if (we_lo) begin
            lo_q <= wd;
        end else if (inc) begin
            lo_q <= lo_q + XLEN'(1);
        end
    end

    // High half: write data wins over the carry, which is then discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
        end else if (we_hi) begin
            hi_q <= wd;
        end else if (carry_to_hi) begin
            hi_q <= hi_q + XLEN'(1);
        end
    end

    assign value = {hi_q, lo_q};

endmodule

// File: rtl/csr_counter_unit.sv
// Machine counter CSR block: mcycle and minstret as 64-bit counters exposed
// through 32-bit halves, plus mcountinhibit. CSR decode, read mux and the
// inhibit register live here; the counting itself is in split_counter64.
// CNT_WIDTH is expected to be exactly 2*XLEN.
module csr_counter_unit
    import csr_pkg::*;
#(
    parameter int             XLEN          = 32,
    parameter int             CNT_WIDTH     = 64,
    parameter logic [2:0]     INHIBIT_RESET = 3'b000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            retire,
    input  logic [11:0]     csr_addr,
    input  logic            csr_we,
    input  logic [XLEN-1:0] csr_wd,
    output logic [XLEN-1:0] csr_rd,
    output logic            csr_hit,
    output logic            csr_illegal
);

    csr_sel_e               sel;
    logic                   read_only;
    logic                   wr_en;
    logic [INH_WIDTH-1:0]   inhibit_q;
    logic                   cycle_inc;
    logic                   instret_inc;
    logic                   cycle_we_lo;
    logic                   cycle_we_hi;
    logic                   instret_we_lo;
    logic                   instret_we_hi;
    logic                   inhibit_we;
    logic [CNT_WIDTH-1:0]   cycle_value;
    logic [CNT_WIDTH-1:0]   instret_value;

    // Decode the address and split the write strobe into per-register enables;
    // writes to the read-only shadows are flagged and otherwise dropped.
    always_comb begin
        sel           = csr_decode(csr_addr);
        read_only     = csr_is_read_only(csr_addr);
        csr_hit       = (sel != SEL_NONE);
        csr_illegal   = csr_we && csr_hit && read_only;
        wr_en         = csr_we && csr_hit && !read_only;
        cycle_we_lo   = wr_en && (sel == SEL_CYCLE_LO);
        cycle_we_hi   = wr_en && (sel == SEL_CYCLE_HI);
        instret_we_lo = wr_en && (sel == SEL_INSTRET_LO);
        instret_we_hi = wr_en && (sel == SEL_INSTRET_HI);
        inhibit_we    = wr_en && (sel == SEL_INHIBIT);
    end

    // Increments use the registered inhibit bits, so a write to mcountinhibit
    // only gates counting from the following cycle.
    always_comb begin
        cycle_inc   = !inhibit_q[INH_CY];
        instret_inc = retire && !inhibit_q[INH_IR];
    end

    // mcountinhibit storage; unimplemented bits are masked so they always read 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            inhibit_q <= INHIBIT_RESET & INH_MASK;
        end else if (inhibit_we) begin
            inhibit_q <= csr_wd[INH_WIDTH-1:0] & INH_MASK;
        end
    end

    split_counter64 #(
        .XLEN      (XLEN),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cycle (
        .clk   (clk),
        .reset (reset),
        .inc   (cycle_inc),
        .we_lo (cycle_we_lo),
        .we_hi (cycle_we_hi),
        .wd    (csr_wd),
        .value (cycle_value)
    );

    split_counter64 #(
        .XLEN      (XLEN),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_instret (
        .clk   (clk),
        .reset (reset),
        .inc   (instret_inc),
        .we_lo (instret_we_lo),
        .we_hi (instret_we_hi),
        .wd    (csr_wd),
        .value (instret_value)
    );

    // Read mux returns the pre-edge contents; unknown addresses read as zero.
    always_comb begin
        csr_rd = '0;
        case (sel)
            SEL_CYCLE_LO:   csr_rd = cycle_value[XLEN-1:0];
            SEL_CYCLE_HI:   csr_rd = cycle_value[CNT_WIDTH-1:XLEN];
            SEL_INSTRET_LO: csr_rd = instret_value[XLEN-1:0];
            SEL_INSTRET_HI: csr_rd = instret_value[CNT_WIDTH-1:XLEN];
            SEL_INHIBIT:    csr_rd = {{(XLEN-INH_WIDTH){1'b0}}, inhibit_q};
            default:        csr_rd = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Self-checking bench for csr_counter_unit: hand-written sequences for reset,
// carry/wrap and inhibit timing, then a table of vectors run with frozen
// counters, then reset with a pending write.
module tb_csr_counter_unit;

    logic        clk;
    logic        reset;
    logic        retire;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wd;
    logic [31:0] csr_rd;
    logic        csr_hit;
    logic        csr_illegal;

    int checks;
    int errors;

    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [31:0] wd;
        logic        ret;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic        exp_ill;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    csr_counter_unit #(
        .XLEN          (32),
        .CNT_WIDTH     (64),
        .INHIBIT_RESET (3'b000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .retire      (retire),
        .csr_addr    (csr_addr),
        .csr_we      (csr_we),
        .csr_wd      (csr_wd),
        .csr_rd      (csr_rd),
        .csr_hit     (csr_hit),
        .csr_illegal (csr_illegal)
    );

    // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one set of inputs and let the combinational outputs settle.
    task automatic applyStimulus(input logic [11:0] addr, input logic we,
                                 input logic [31:0] wd, input logic ret);
        csr_addr = addr;
        csr_we   = we;
        csr_wd   = wd;
        retire   = ret;
        #1;
    endtask

    // Compare all three outputs against expectations as one check.
    task automatic checkOutput(input string name, input logic [31:0] exp_rd,
                               input logic exp_hit, input logic exp_ill);
        checks++;
        if (csr_rd !== exp_rd || csr_hit !== exp_hit || csr_illegal !== exp_ill) begin
            errors++;
            $display("[TB] FAIL %s: addr=%h got rd=%h hit=%b ill=%b, expected rd=%h hit=%b ill=%b",
                     name, csr_addr, csr_rd, csr_hit, csr_illegal, exp_rd, exp_hit, exp_ill);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        retire   = 1'b0;
        csr_addr = 12'h000;
        csr_we   = 1'b0;
        csr_wd   = 32'h0;

        // Counters are frozen (inhibit = 5) while these run; mcycle = 5_00000001,
        // minstret = 1 at entry.
        vecs[0]  = '{12'hC02, 1'b1, 32'h0000_1234, 1'b0, 32'h0000_0001, 1'b1, 1'b1};
        vecs[1]  = '{12'hB02, 1'b0, 32'h0,         1'b0, 32'h0000_0001, 1'b1, 1'b0};
        vecs[2]  = '{12'h7C0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
        vecs[3]  = '{12'h7C0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[4]  = '{12'h320, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0005, 1'b1, 1'b0};
        vecs[5]  = '{12'h320, 1'b0, 32'h0,         1'b0, 32'h0000_0005, 1'b1, 1'b0};
        vecs[6]  = '{12'hB82, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1, 1'b0};
        vecs[7]  = '{12'hB02, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
        vecs[8]  = '{12'hB82, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[9]  = '{12'hC82, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[10] = '{12'hC80, 1'b1, 32'h0,         1'b0, 32'h0000_0005, 1'b1, 1'b1};
        vecs[11] = '{12'hB80, 1'b0, 32'h0,         1'b0, 32'h0000_0005, 1'b1, 1'b0};
        vecs[12] = '{12'h320, 1'b1, 32'h0000_0001, 1'b1, 32'h0000_0005, 1'b1, 1'b0};
        vecs[13] = '{12'h320, 1'b0, 32'h0,         1'b1, 32'h0000_0001, 1'b1, 1'b0};
        vecs[14] = '{12'hB02, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0};
        vecs[15] = '{12'hB82, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0};
        vecs[16] = '{12'hC00, 1'b0, 32'h0,         1'b0, 32'h0000_0001, 1'b1, 1'b0};
        vecs[17] = '{12'h321, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
        vecs[18] = '{12'hB01, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
        vecs[19] = '{12'hB03, 1'b1, 32'h0000_0077, 1'b0, 32'h0,         1'b0, 1'b0};

        // Reset for two edges, then release and check the reset state.
        nextCycle();
        nextCycle();
        reset = 1'b0;
        applyStimulus(12'hB00, 1'b0, 32'h0, 1'b0);
        checkOutput("reset_mcycle", 32'h0, 1'b1, 1'b0);
        applyStimulus(12'hB02, 1'b0, 32'h0, 1'b0);
        checkOutput("reset_minstret", 32'h0, 1'b1, 1'b0);
        applyStimulus(12'h320, 1'b0, 32'h0, 1'b0);
        checkOutput("reset_inhibit", 32'h0, 1'b1, 1'b0);

        // Ten idle cycles: mcycle = 10.
        repeat (10) nextCycle();
        applyStimulus(12'hB00, 1'b0, 32'h0, 1'b0);
        checkOutput("idle_mcycle", 32'd10, 1'b1, 1'b0);
        applyStimulus(12'hC00, 1'b0, 32'h0, 1'b0);
        checkOutput("idle_cycle_shadow", 32'd10, 1'b1, 1'b0);
        applyStimulus(12'hB80, 1'b0, 32'h0, 1'b0);
        checkOutput("idle_mcycleh", 32'h0, 1'b1, 1'b0);

        // Low-half write replaces the increment, then carry after two cycles.
        applyStimulus(12'hB00, 1'b1, 32'hFFFF_FFFE, 1'b0);
        checkOutput("wr_lo_pre_edge", 32'd10, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(12'hB00, 1'b0, 32'h0, 1'b0);
        checkOutput("lo_after_write", 32'hFFFF_FFFE, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(12'hB00, 1'b0, 32'h0, 1'b0);
        checkOutput("lo_all_ones", 32'hFFFF_FFFF, 1'b1, 1'b0);
        applyStimulus(12'hB80, 1'b0, 32'h0, 1'b0);
        checkOutput("hi_before_carry", 32'h0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(12'hB80, 1'b0, 32'h0, 1'b0);
        checkOutput("hi_after_carry", 32'h1, 1'b1, 1'b0);
        applyStimulus(12'hB00, 1'b0, 32'h0, 1'b0);
        checkOutput("lo_after_carry", 32'h0, 1'b1, 1'b0);

        // High-half write on the wrap cycle drops the carry.
        applyStimulus(12'hB00, 1'b1, 32'hFFFF_FFFF, 1'b0);
        nextCycle();
        applyStimulus(12'hB80, 1'b1, 32'h0000_0005, 1'b0);
        checkOutput("wr_hi_pre_edge", 32'h1, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(12'hB80, 1'b0, 32'h0, 1'b0);
        checkOutput("hi_write_no_carry", 32'h5, 1'b1, 1'b0);
        applyStimulus(12'hB00, 1'b0, 32'h0, 1'b0);
        checkOutput("lo_wrapped", 32'h0, 1'b1, 1'b0);

        // Inhibit both counters; the write cycle itself still counts.
        applyStimulus(12'h320, 1'b1, 32'h0000_0005, 1'b1);
        checkOutput("wr_inhibit_pre_edge", 32'h0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(12'hB00, 1'b0, 32'h0, 1'b1);
        checkOutput("inh_write_cycle_counts_cy", 32'h1, 1'b1, 1'b0);
        applyStimulus(12'hB02, 1'b0, 32'h0, 1'b1);
        checkOutput("inh_write_cycle_counts_ir", 32'h1, 1'b1, 1'b0);
        applyStimulus(12'h320, 1'b0, 32'h0, 1'b1);
        checkOutput("inhibit_readback", 32'h5, 1'b1, 1'b0);
        repeat (8) nextCycle();
        applyStimulus(12'hB00, 1'b0, 32'h0, 1'b1);
        checkOutput("frozen_mcycle", 32'h1, 1'b1, 1'b0);
        applyStimulus(12'hB80, 1'b0, 32'h0, 1'b1);
        checkOutput("frozen_mcycleh", 32'h5, 1'b1, 1'b0);
        applyStimulus(12'hB02, 1'b0, 32'h0, 1'b1);
        checkOutput("frozen_minstret", 32'h1, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(12'hB82, 1'b0, 32'h0, 1'b1);
        checkOutput("frozen_minstreth", 32'h0, 1'b1, 1'b0);
        applyStimulus(12'hC02, 1'b0, 32'h0, 1'b1);
        checkOutput("frozen_instret_shadow", 32'h1, 1'b1, 1'b0);

        // Table-driven vectors, one per cycle.
        for (int i = 0; i < NVEC; i++) begin
            nextCycle();
            applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].wd, vecs[i].ret);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_hit, vecs[i].exp_ill);
        end

        // Reset with a write and a retire pending: both are lost.
        nextCycle();
        reset = 1'b1;
        applyStimulus(12'hB00, 1'b1, 32'h0000_1234, 1'b1);
        nextCycle();
        reset = 1'b0;
        applyStimulus(12'hB00, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_mcycle", 32'h0, 1'b1, 1'b0);
        applyStimulus(12'hB80, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_mcycleh", 32'h0, 1'b1, 1'b0);
        applyStimulus(12'hB02, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_minstret", 32'h0, 1'b1, 1'b0);
        applyStimulus(12'h320, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_inhibit", 32'h0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(12'hB00, 1'b0, 32'h0, 1'b0);
        checkOutput("post_rst_counting", 32'h1, 1'b1, 1'b0);
        applyStimulus(12'hB82, 1'b0, 32'h0, 1'b0);
        checkOutput("post_rst_minstreth", 32'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
